dff_chain_seq: RTL and testbench

//  Sequencer for a serial chain of WIDTH D flip-flops (dff cells, power-up q=1).

---
 rtl/dff_chain_seq.sv | 87 ++++++++
 tb/tb_dff_chain_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dff_chain_seq.sv
// Sequencer that shifts a parallel word LSB-first into a serial DFF chain
// and returns the bits falling out of the chain tail as a parallel word.
module dff_chain_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             hold,
    output logic             ser_en,
    output logic             ser_d,
    input  logic             ser_q,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] cap_sr_q, cap_sr_d;
    logic [WIDTH-1:0] cap_data_q, cap_data_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tx_d       = tx_q;
        cap_sr_d   = cap_sr_q;
        cap_data_d = cap_data_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    tx_d    = load_data;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!hold) begin
                    tx_d = tx_q >> 1;
                    // Tail bit sampled at shift edge k is old chain bit k.
                    cap_sr_d[count_q[IW-1:0]] = ser_q;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        cap_data_d = cap_sr_d;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            tx_q       <= '0;
            cap_sr_q   <= '0;
            cap_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            cap_sr_q   <= cap_sr_d;
            cap_data_q <= cap_data_d;
        end
    end

    // Gating load_ready with reset keeps every output low while reset is held.
    assign load_ready = (state_q == S_IDLE) && !reset;
    assign ser_en     = (state_q == S_SHIFT) && !hold;
    assign ser_d      = (state_q == S_SHIFT) && tx_q[0];
    assign cap_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign cap_data   = cap_data_q;

endmodule

// File: tb/tb_dff_chain_seq.sv
// Bench for dff_chain_seq: behavioural chain plus a transaction-level model
// of each load (bits sent, holds seen, expected capture) checked every cycle.
module tb_dff_chain_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         hold = 1'b0;
    logic         ser_en, ser_d, ser_q;
    logic [W-1:0] cap_data;
    logic         cap_valid, busy;

    // Behavioural flip-flop chain; powers up all ones, never reset.
    logic [W-1:0] chain = '1;

    int n_chk = 0;
    int n_fail = 0;

    // Transaction model state
    bit           m_active = 0;
    int           m_sent = 0;
    int           m_cyc = 0;
    int           m_holds = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_exp = '0;
    logic [W-1:0] m_last = '0;
    int           n_acc = 0;
    int           n_done = 0;

    dff_chain_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .hold(hold), .ser_en(ser_en), .ser_d(ser_d),
        .ser_q(ser_q), .cap_data(cap_data), .cap_valid(cap_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ser_q = chain[W-1];
    always @(posedge clk) if (ser_en) chain <= {chain[W-2:0], ser_d};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply inputs for the coming edge, then check outputs against the model.
    task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic h);
        @(negedge clk);
        rst = r; load_valid = lv; load_data = d; hold = h;
        #1;
        if (m_active) m_cyc++;
        if (r) begin
            chk("rst_ready", load_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cvld", cap_valid, 0);
            chk("rst_sen", ser_en, 0);
            chk("rst_sd", ser_d, 0);
            chk("rst_cdata", cap_data, 0);
            m_active = 0;
            m_last = '0;
        end else if (!m_active) begin
            chk("idle_ready", load_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_cvld", cap_valid, 0);
            chk("idle_sen", ser_en, 0);
            chk("idle_sd", ser_d, 0);
            chk("idle_cdata", cap_data, m_last);
            if (lv) begin
                m_active = 1; m_sent = 0; m_cyc = 0; m_holds = 0;
                m_word = d;
                for (int k = 0; k < W; k++) m_exp[k] = chain[W-1-k];
                n_acc++;
            end
        end else if (m_sent < W) begin
            chk("sh_ready", load_ready, 0);
            chk("sh_busy", busy, 1);
            chk("sh_cvld", cap_valid, 0);
            chk("sh_sen", ser_en, !h);
            chk("sh_cdata", cap_data, m_last);
            if (!h) begin
                chk("sh_sd", ser_d, m_word[m_sent]);
                m_sent++;
            end else begin
                m_holds++;
            end
        end else begin
            chk("dn_cvld", cap_valid, 1);
            chk("dn_busy", busy, 1);
            chk("dn_ready", load_ready, 0);
            chk("dn_sen", ser_en, 0);
            chk("dn_cdata", cap_data, m_exp);
            chk("dn_latency", m_cyc, W + 1 + m_holds);
            m_last = m_exp;
            m_active = 0;
            n_done++;
        end
    endtask

    task automatic run_until_sent(input int n);
        int lim = 200;
        while (!(m_active && m_sent >= n) && lim > 0) begin
            step(0, 0, '0, 0);
            lim--;
        end
        if (lim == 0) chk("timeout_sent", 0, 1);
    endtask

    task automatic run_idle();
        int lim = 200;
        while (m_active && lim > 0) begin
            step(0, 0, '0, 0);
            lim--;
        end
        if (lim == 0) chk("timeout_idle", 0, 1);
    endtask

    initial begin
        int a0;
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);

        // 1: first load returns power-up contents
        step(0, 1, 8'hA5, 0);
        run_idle();
        step(0, 0, '0, 0);
        chk("t1_cap", cap_data, 8'hFF);

        // 2: each load returns the previous word
        step(0, 1, 8'h3C, 0);
        run_idle();
        step(0, 0, '0, 0);
        chk("t2_cap_a5", cap_data, 8'hA5);
        step(0, 1, 8'h00, 0);
        run_idle();
        step(0, 0, '0, 0);
        chk("t2_cap_3c", cap_data, 8'h3C);

        // 3: hold for three cycles at bit 4
        step(0, 1, 8'h96, 0);
        run_until_sent(4);
        repeat (3) step(0, 0, '0, 1);
        run_idle();
        step(0, 0, '0, 0);
        chk("t3_cap", cap_data, 8'h00);

        // 4: load_valid held high; one accept per W+2 cycles
        a0 = n_acc;
        for (int i = 0; i < 40; i++) step(0, 1, W'(8'h10 + i), 0);
        chk("t4_acc", n_acc - a0, 4);
        run_idle();

        // 5: reset during bit 5, then a normal load
        step(0, 1, 8'h5A, 0);
        run_until_sent(5);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 1, 8'h81, 0);
        run_idle();
        step(0, 1, 8'h42, 0);
        run_idle();
        step(0, 0, '0, 0);
        chk("t5_cap_81", cap_data, 8'h81);

        // 6: load_valid only in the DONE cycle is ignored
        step(0, 1, 8'h11, 0);
        run_until_sent(W);
        a0 = n_acc;
        step(0, 1, 8'h55, 0);
        step(0, 0, '0, 0);
        chk("t6_noacc", n_acc - a0, 0);
        chk("t6_ready", load_ready, 1);
        chk("t6_busy", busy, 0);

        // Random traffic, holds and occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom % 400) == 0, ($urandom % 3) == 0, W'($urandom), ($urandom % 4) == 0);
        run_idle();
        step(0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
